// File: rtl/bit_stuffer_if.sv
// ============================================================================
// bit_stuffer_if : serial-in / line-out bundle for the bit stuffer stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface bit_stuffer_if #(
  parameter int CNT_W = 8
) ();
  logic             in_bit;
  logic             in_valid;
  logic             in_first;
  logic             in_last;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic             out_stuffed;
  logic [CNT_W-1:0] stuff_count;

  // Upstream serializer plus line consumer.
  modport master (
    output in_bit, in_valid, in_first, in_last,
    input  in_ready, out_bit, out_valid, out_last, out_stuffed, stuff_count
  );

  // The stuffer itself.
  modport slave (
    input  in_bit, in_valid, in_first, in_last,
    output in_ready, out_bit, out_valid, out_last, out_stuffed, stuff_count
  );
endinterface

`default_nettype wire

// File: rtl/bit_stuffer.sv
// ============================================================================
// bit_stuffer : inserts STUFF_BIT after RUN_LEN consecutive 1s, with framing
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bit_stuffer #(
  parameter int   RUN_LEN   = 6,
  parameter logic STUFF_BIT = 1'b0,
  parameter int   CNT_W     = 8
) (
  input wire clk,
  input wire rst_b,
  bit_stuffer_if.slave bus
);

  localparam logic [0:0]       ST_PASS  = 1'b0;
  localparam logic [0:0]       ST_STUFF = 1'b1;
  localparam logic [3:0]       RUN_MAX  = 4'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             pend_last_q, pend_last_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_stuffed_q, out_stuffed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       w_ready;
  logic       w_accept;
  logic [3:0] w_run_eff;

  assign w_ready   = (state_q == ST_PASS);
  assign w_accept  = bus.in_valid & w_ready;
  // A first bit always starts a fresh run, whatever the previous packet left.
  assign w_run_eff = bus.in_first ? 4'd0 : run_q;

  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    pend_last_d   = pend_last_q;
    out_bit_d     = out_bit_q;
    out_valid_d   = 1'b0;
    out_last_d    = 1'b0;
    out_stuffed_d = 1'b0;
    cnt_d         = cnt_q;

    case (state_q)
      ST_PASS: begin
        if (w_accept) begin
          out_bit_d   = bus.in_bit;
          out_valid_d = 1'b1;
          if (bus.in_first) begin
            cnt_d = '0;
          end
          if (!bus.in_bit) begin
            run_d      = 4'd0;
            out_last_d = bus.in_last;
          end else if (w_run_eff == RUN_MAX) begin
            // Last-bit framing moves onto the stuff bit that follows.
            run_d       = 4'd0;
            state_d     = ST_STUFF;
            pend_last_d = bus.in_last;
            out_last_d  = 1'b0;
          end else begin
            run_d      = w_run_eff + 4'd1;
            out_last_d = bus.in_last;
          end
          if (bus.in_last && !(bus.in_bit && (w_run_eff == RUN_MAX))) begin
            run_d = 4'd0;
          end
        end
      end
      ST_STUFF: begin
        // The inserted bit never contributes to the run, even when it is a 1.
        out_bit_d     = STUFF_BIT;
        out_valid_d   = 1'b1;
        out_stuffed_d = 1'b1;
        out_last_d    = pend_last_q;
        cnt_d         = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);
        pend_last_d   = 1'b0;
        state_d       = ST_PASS;
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_PASS;
      run_q         <= 4'd0;
      pend_last_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_stuffed_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      pend_last_q   <= pend_last_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_stuffed_q <= out_stuffed_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_bit     = out_bit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_stuffed = out_stuffed_q;
  assign bus.stuff_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_stuffer.sv
// ============================================================================
// tb_bit_stuffer : directed vectors for bit_stuffer (RUN_LEN=6, CNT_W 8 and 2)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bit_stuffer;

  logic clk = 1'b0;
  logic rst_b;
  logic rst2_b;

  always #5 clk = ~clk;

  bit_stuffer_if #(.CNT_W(8)) bus ();
  bit_stuffer_if #(.CNT_W(2)) bus2 ();

  // The saturation instance sees the same serial stream.
  assign bus2.in_bit   = bus.in_bit;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_first = bus.in_first;
  assign bus2.in_last  = bus.in_last;

  bit_stuffer #(.RUN_LEN(6), .STUFF_BIT(1'b0), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  bit_stuffer #(.RUN_LEN(6), .STUFF_BIT(1'b0), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_b (rst2_b),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {out_bit, out_stuffed, out_last} of every valid line bit.
  logic [2:0] obs[$];

  always @(negedge clk) begin
    if (bus.out_valid) obs.push_back({bus.out_bit, bus.out_stuffed, bus.out_last});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one bit and holds it until accepted; returns stall cycles seen.
  task automatic send(input logic b, input logic f, input logic l, output int stalls);
    logic rdy;
    stalls = 0;
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_last  = l;
    for (int g = 0; g < 8; g++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalls++;
      if (g == 7) check_eq("send_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_str(input string s, input logic f, input logic l, output int stalls);
    int st;
    stalls = 0;
    for (int i = 0; i < s.len(); i++) begin
      send(s[i] == "1", f && (i == 0), l && (i == s.len() - 1), st);
      stalls += st;
    end
  endtask

  task automatic idle(input int n, input logic chk_gap);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (chk_gap) check_eq($sformatf("gap_valid[%0d]", i), bus.out_valid, 1'b0);
    end
  endtask

  task automatic expect_stream(input string tag, input string b, input string s, input string l);
    logic [2:0] e;
    check_eq({tag, ".len"}, obs.size(), b.len());
    for (int i = 0; i < b.len(); i++) begin
      e = {b[i] == "1", s[i] == "1", l[i] == "1"};
      if (i < obs.size()) check_eq($sformatf("%s[%0d]", tag, i), obs[i], e);
    end
    obs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int tot;

    rst_b        = 1'b0;
    rst2_b       = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    #2;
    check_eq("rst_ready",   bus.in_ready,    1'b1);
    check_eq("rst_valid",   bus.out_valid,   1'b0);
    check_eq("rst_bit",     bus.out_bit,     1'b0);
    check_eq("rst_last",    bus.out_last,    1'b0);
    check_eq("rst_stuffed", bus.out_stuffed, 1'b0);
    check_eq("rst_count",   bus.stuff_count, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_b  = 1'b1;
    rst2_b = 1'b1;
    idle(2, 1'b0);
    obs.delete();

    // 1: seven 1s then 0 in one contiguous packet.
    send_str("111111", 1'b1, 1'b0, st);
    check_eq("t1_ready_low", bus.in_ready, 1'b0);
    check_eq("t1_6th_not_stuffed", bus.out_stuffed, 1'b0);
    send_str("10", 1'b0, 1'b1, st);
    check_eq("t1_stalls", st, 1);
    idle(2, 1'b0);
    expect_stream("t1", "111111010", "000000100", "000000001");
    check_eq("t1_count", bus.stuff_count, 8'd1);

    // 2: runs of five never stuff.
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      send_str("111110", k == 0, k == 3, st);
      tot += st;
    end
    check_eq("t2_stalls", tot, 0);
    idle(2, 1'b0);
    expect_stream("t2", "111110111110111110111110",
                        "000000000000000000000000",
                        "000000000000000000000001");
    check_eq("t2_count", bus.stuff_count, 8'd0);

    // 3: stuff triggered by the last bit carries out_last; single-bit packet follows.
    send_str("111111", 1'b1, 1'b1, st);
    check_eq("t3_stalls_pkt", st, 0);
    check_eq("t3_ready_low", bus.in_ready, 1'b0);
    send(1'b0, 1'b1, 1'b1, st);
    check_eq("t3_stalls_next", st, 1);
    idle(2, 1'b0);
    expect_stream("t3", "11111100", "00000010", "00000011");
    check_eq("t3_count", bus.stuff_count, 8'd0);

    // 4: idle gap holds the run.
    send_str("111", 1'b1, 1'b0, st);
    idle(3, 1'b1);
    send_str("111", 1'b0, 1'b0, st);
    send_str("0", 1'b0, 1'b1, st);
    check_eq("t4_stalls", st, 1);
    idle(2, 1'b0);
    expect_stream("t4", "11111100", "00000010", "00000001");
    check_eq("t4_count", bus.stuff_count, 8'd1);

    // 5: in_first restarts the run and the count.
    send_str("1111", 1'b0, 1'b0, st);
    check_eq("t5_count_hold", bus.stuff_count, 8'd1);
    send(1'b1, 1'b1, 1'b0, st);
    check_eq("t5_count_clr", bus.stuff_count, 8'd0);
    send_str("11111", 1'b0, 1'b0, st);
    send_str("0", 1'b0, 1'b1, st);
    check_eq("t5_stalls", st, 1);
    idle(2, 1'b0);
    expect_stream("t5", "111111111100", "000000000010", "000000000001");
    check_eq("t5_count", bus.stuff_count, 8'd1);

    // 6a: reset asserted during the stuff cycle drops the pending stuff bit.
    send_str("111111", 1'b0, 1'b0, st);
    bus.in_valid = 1'b0;
    check_eq("t6_in_stuff", bus.in_ready, 1'b0);
    rst_b = 1'b0;
    #1;
    check_eq("t6_rst_ready",   bus.in_ready,    1'b1);
    check_eq("t6_rst_valid",   bus.out_valid,   1'b0);
    check_eq("t6_rst_bit",     bus.out_bit,     1'b0);
    check_eq("t6_rst_stuffed", bus.out_stuffed, 1'b0);
    check_eq("t6_rst_count",   bus.stuff_count, 8'd0);
    @(negedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    idle(3, 1'b1);
    expect_stream("t6a", "11111", "00000", "00000");

    // 6b: five stuffs in one packet; CNT_W=2 saturates at 3.
    send_str("111111111111111111111111111111", 1'b1, 1'b1, st);
    check_eq("t6b_stalls", st, 4);
    idle(2, 1'b0);
    expect_stream("t6b", "11111101111110111111011111101111110",
                         "00000010000001000000100000010000001",
                         "00000000000000000000000000000000001");
    check_eq("t6b_count8", bus.stuff_count, 8'd5);
    check_eq("t6b_count2", bus2.stuff_count, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
